// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES arbiter slice.
// State encoding, block width and statistics counter width live here.
package aes_pkg;

   localparam int AES_BLK_W = 128;
   localparam int STAT_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] bb;
      p  = '0;
      x  = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ x;
         x  = xtime(x);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // S-box computed as x^254 (multiplicative inverse) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes128_encrypt.sv
// Combinational AES-128 encrypt core, fully unrolled with on-the-fly key
// expansion. Byte 0 of a block is bits [127:120], columns are 32-bit groups.
module aes128_encrypt
   import aes_pkg::*;
(
   input  logic [AES_BLK_W-1:0] pt,
   input  logic [AES_BLK_W-1:0] key,
   output logic [AES_BLK_W-1:0] ct
);

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(4*c+w) -: 8] = sbox(s[127-8*(4*((c+w)%4)+w) -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127-32*c -: 32];
         r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return r;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      {w0, w1, w2, w3} = k;
      t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k);
      logic [127:0] s, rk;
      logic [7:0]   rc;
      rk = k;
      rc = 8'h01;
      s  = p ^ k;
      for (int r = 1; r <= 10; r++) begin
         rk = next_key(rk, rc);
         rc = xtime(rc);
         s  = (r == 10) ? (sub_shift(s) ^ rk) : (mix_cols(sub_shift(s)) ^ rk);
      end
      return s;
   endfunction

   assign ct = encrypt(pt, key);

endmodule

// File: rtl/aes_rr_pick.sv
// Round-robin picker: searches from last_grant+1 (mod NUM_REQ) for the
// first asserted request and returns a one-hot grant plus its index.
module aes_rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] idx
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [IDW-1:0] cand;

   // Walk from the farthest offset down so the nearest requester is kept last
   always_comb begin
      gnt  = '0;
      idx  = '0;
      cand = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = IDW'((int'(last_grant) + i) % NUM_REQ);
         if (req[cand]) begin
            gnt       = '0;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/aes_arbiter.sv
// Round-robin arbiter sharing one AES-128 core across NUM_REQ requesters.
// Define AES_ARB_STATS_EN to add per-requester completion counters (stat_count).
//
// state   | meaning
// IDLE    | offering req_ready to the round-robin winner
// CALC    | registered pt/key settling through the core for CALC_CYCLES
// RESP    | rsp_ct/rsp_id/rsp_valid held until rsp_ready
module aes_arbiter
   import aes_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int CALC_CYCLES = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*AES_BLK_W-1:0]   req_pt,
   input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [AES_BLK_W-1:0]           rsp_ct,
`ifdef AES_ARB_STATS_EN
   output logic [NUM_REQ*STAT_W-1:0]      stat_count,
`endif
   output logic [$clog2(NUM_REQ)-1:0]     rsp_id
);
   localparam int IDW = $clog2(NUM_REQ);

   state_t               state;
   logic [3:0]           cnt;
   logic [IDW-1:0]       last_grant;
   logic [IDW-1:0]       pick_idx;
   logic [NUM_REQ-1:0]   pick_gnt;
   logic [AES_BLK_W-1:0] pt_q, key_q, core_ct, sel_pt, sel_key;
   logic                 accept;

   aes_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .gnt        (pick_gnt),
      .idx        (pick_idx)
   );

   aes128_encrypt u_core (
      .pt  (pt_q),
      .key (key_q),
      .ct  (core_ct)
   );

   assign req_ready = (rst_n && state == ST_IDLE) ? pick_gnt : '0;
   assign accept    = |req_ready;

   always_comb begin
      sel_pt  = '0;
      sel_key = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDW'(i)) begin
            sel_pt  = req_pt[AES_BLK_W*i +: AES_BLK_W];
            sel_key = req_key[AES_BLK_W*i +: AES_BLK_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last_grant <= IDW'(NUM_REQ - 1);
         rsp_valid  <= 1'b0;
         rsp_ct     <= '0;
         rsp_id     <= '0;
         pt_q       <= '0;
         key_q      <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  pt_q   <= sel_pt;
                  key_q  <= sel_key;
                  rsp_id <= pick_idx;
                  cnt    <= 4'(CALC_CYCLES - 1);
                  state  <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (cnt == '0) begin
                  rsp_ct    <= core_ct;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  last_grant <= rsp_id;
                  rsp_valid  <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef AES_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [NUM_REQ];

   // Counters saturate rather than wrap so a stuck-busy requester stays visible
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
      end else if (state == ST_RESP && rsp_ready) begin
         for (int i = 0; i < NUM_REQ; i++)
            if (rsp_id == IDW'(i) && stat_q[i] != '1) stat_q[i] <= stat_q[i] + 1'b1;
      end
   end

   always_comb begin
      stat_count = '0;
      for (int i = 0; i < NUM_REQ; i++) stat_count[STAT_W*i +: STAT_W] = stat_q[i];
   end
`endif

endmodule

// File: tb/tb_aes_arbiter.sv
// Directed bench for aes_arbiter: reset values, FIPS-197 vectors, response
// stall, reset during CALC and round-robin ordering.
module tb_aes_arbiter;
   localparam int NUM_REQ = 4;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*128-1:0] req_pt;
   logic [NUM_REQ*128-1:0] req_key;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [127:0]           rsp_ct;
   logic [1:0]             rsp_id;
`ifdef AES_ARB_STATS_EN
   logic [NUM_REQ*16-1:0]  stat_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   aes_arbiter #(.NUM_REQ(NUM_REQ), .CALC_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_pt     (req_pt),
      .req_key    (req_key),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_ct     (rsp_ct),
`ifdef AES_ARB_STATS_EN
      .stat_count (stat_count),
`endif
      .rsp_id     (rsp_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [127:0] exp_ct [NUM_REQ];
   int           g_id  [8];
   int           g_cyc [8];
   int           st_m  [NUM_REQ];
   int           ngr;
   int           pend;

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b0;
      req_pt    = '0;
      req_key   = '0;
      ngr       = 0;
      pend      = 0;
      for (int i = 0; i < NUM_REQ; i++) st_m[i] = 0;

      // reset values, with requests asserted to confirm req_ready stays low
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 128'(req_ready), 128'h0);
      check("rst_valid", 128'(rsp_valid), 128'h0);
      check("rst_ct",    rsp_ct,          128'h0);
      check("rst_id",    128'(rsp_id),    128'h0);

      // FIPS-197 C.1 on requester 2
      req_valid = '0;
      rst_n     = 1'b1;
      req_pt[256 +: 128]  = C1_PT;
      req_key[256 +: 128] = C1_KEY;
      req_valid = 4'b0100;
      #1;
      check("fips_gnt", 128'(req_ready), 128'h4);
      tick();
      req_valid = '0;
      check("calc_ready", 128'(req_ready), 128'h0);
      check("calc_valid0", 128'(rsp_valid), 128'h0);
      tick();
      check("calc_valid1", 128'(rsp_valid), 128'h0);
      tick();
      check("fips_valid", 128'(rsp_valid), 128'h1);
      check("fips_ct",    rsp_ct,          C1_CT);
      check("fips_id",    128'(rsp_id),    128'h2);

      // hold off the response for 5 cycles with all requesters waiting
      req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("stall_valid", 128'(rsp_valid), 128'h1);
         check("stall_ct",    rsp_ct,          C1_CT);
         check("stall_id",    128'(rsp_id),    128'h2);
         check("stall_ready", 128'(req_ready), 128'h0);
      end
      rsp_ready = 1'b1;
      check("hs_ready", 128'(req_ready), 128'h0);
      tick();
      check("hs_valid", 128'(rsp_valid), 128'h0);
      check("hs_next",  128'(req_ready), 128'h8);
      req_valid = '0;
      rsp_ready = 1'b0;

      // requester 1 accepted, then reset while the block is in CALC
      req_pt[128 +: 128]  = B_PT;
      req_key[128 +: 128] = B_KEY;
      req_valid = 4'b0010;
      #1;
      check("rc_gnt", 128'(req_ready), 128'h2);
      tick();
      req_valid = '0;
      rst_n     = 1'b0;
      check("rc_calc_ready", 128'(req_ready), 128'h0);
      tick();
      check("rc_valid", 128'(rsp_valid), 128'h0);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("rc_stale", 128'(rsp_valid), 128'h0);
      end
      req_valid = '1;
      #1;
      check("rc_first", 128'(req_ready), 128'h1);

      // round robin with every requester active and rsp_ready high
      req_pt[0 +: 128]    = C1_PT;
      req_key[0 +: 128]   = C1_KEY;
      req_pt[256 +: 128]  = '0;
      req_key[256 +: 128] = '0;
      req_pt[384 +: 128]  = C1_PT;
      req_key[384 +: 128] = C1_KEY;
      exp_ct[0] = C1_CT;
      exp_ct[1] = B_CT;
      exp_ct[2] = Z_CT;
      exp_ct[3] = C1_CT;
      #1;
      for (int cyc = 0; cyc < 32; cyc++) begin
         if (req_ready != '0 && ngr < 8) begin
            for (int i = 0; i < NUM_REQ; i++)
               if (req_ready[i]) begin
                  g_id[ngr] = i;
                  pend      = i;
               end
            g_cyc[ngr] = cyc;
            ngr++;
         end
         if (rsp_valid) begin
            check("rr_id", 128'(rsp_id), 128'(pend));
            check("rr_ct", rsp_ct, exp_ct[rsp_id]);
            st_m[rsp_id]++;
         end
         if (cyc == 22) req_valid = '0;
         tick();
      end
      check("rr_ngr", 128'(ngr >= 5), 128'h1);
      for (int k = 0; k < 5; k++) begin
         if (k < ngr) check("rr_order", 128'(g_id[k]), 128'(k % NUM_REQ));
         if (k >= 1 && k < ngr) check("rr_space", 128'(g_cyc[k] - g_cyc[k-1]), 128'h4);
      end
      check("end_valid", 128'(rsp_valid), 128'h0);
      check("end_ready", 128'(req_ready), 128'h0);

`ifdef AES_ARB_STATS_EN
      for (int i = 0; i < NUM_REQ; i++)
         check("stat", 128'(stat_count[16*i +: 16]), 128'(st_m[i]));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
